// File: rtl/l_stf_stream_gen_if.sv
// Sample-stream bus between the L-STF generator and the downstream TX sample mux.
interface l_stf_stream_gen_if #(
  parameter int unsigned IQ_WIDTH = 16
) ();
  logic [2*IQ_WIDTH-1:0] o_iq;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;

  modport master (output o_iq, output o_valid, output o_last, input  i_ready);
  modport slave  (input  o_iq, input  o_valid, input  o_last, output i_ready);
endinterface

// File: rtl/l_stf_stream_gen.sv
// Sequenced L-STF preamble source: streams NUM_REP periods of the 16-sample short training symbol.
// Optional STF_WINDOW_EN: half-amplitude first sample plus one appended half-amplitude tail sample.
module l_stf_stream_gen #(
  parameter int unsigned IQ_WIDTH = 16,
  parameter int unsigned NUM_REP  = 10
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 gain_sel,
  l_stf_stream_gen_if.master         bus,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IQ_W  = 2 * IQ_WIDTH;
  localparam int unsigned EXT_W = IQ_WIDTH + 16;
  localparam logic [3:0]  LAST_REP = 4'(NUM_REP - 1);
`ifdef STF_WINDOW_EN
  localparam logic FIRST_HALF = 1'b1;
`else
  localparam logic FIRST_HALF = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      rep_q, rep_d;
  logic [1:0]      gain_q, gain_d;
  logic [IQ_W-1:0] iq_q, iq_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      nidx;
  logic [3:0]      nrep;
  logic            xfer;

  // Base 16-bit {I,Q} table; the symbol has period 8 so only idx[2:0] matters.
  function automatic logic [31:0] stf_base(input logic [2:0] i);
    logic [31:0] v;
    v = 32'h0;
    case (i)
      3'd0: v = {16'h02f2, 16'h02f2};
      3'd1: v = {16'h0000, 16'hfbd6};
      3'd2: v = {16'hfd0e, 16'h02f2};
      3'd3: v = {16'h042a, 16'h0000};
      3'd4: v = {16'hfd0e, 16'hfd0e};
      3'd5: v = {16'h0000, 16'h042a};
      3'd6: v = {16'h02f2, 16'hfd0e};
      3'd7: v = {16'hfbd6, 16'h0000};
    endcase
    return v;
  endfunction

  // Width scaling, gain and optional half-amplitude folded into one floor shift of v*2^IQ_WIDTH.
  function automatic logic [IQ_W-1:0] stf_sample(input logic [3:0] i,
                                                 input logic [1:0] g,
                                                 input logic       half);
    logic [31:0]             base;
    logic signed [EXT_W-1:0] ei;
    logic signed [EXT_W-1:0] eq;
    logic [4:0]              sh;
    base = stf_base(i[2:0]);
    ei   = {base[31:16], {IQ_WIDTH{1'b0}}};
    eq   = {base[15:0],  {IQ_WIDTH{1'b0}}};
    sh   = 5'd16 + 5'(g) + 5'(half);
    return {IQ_WIDTH'(ei >>> sh), IQ_WIDTH'(eq >>> sh)};
  endfunction

  assign xfer = valid_q & bus.i_ready;
  assign nidx = idx_q + 4'd1;
  assign nrep = (idx_q == 4'd15) ? rep_q + 4'd1 : rep_q;

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rep_q   <= '0;
      gain_q  <= '0;
      iq_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gain_q  <= gain_d;
      iq_q    <= iq_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gain_d  = gain_q;
    iq_d    = iq_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      rep_d   = '0;
      iq_d    = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            gain_d  = gain_sel;
            idx_d   = '0;
            rep_d   = '0;
            iq_d    = stf_sample(4'd0, gain_sel, FIRST_HALF);
            valid_d = 1'b1;
            last_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (last_q) begin
              state_d = S_DONE;
              idx_d   = '0;
              rep_d   = '0;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
`ifdef STF_WINDOW_EN
              if (idx_q == 4'd15 && rep_q == LAST_REP) begin
                iq_d   = stf_sample(4'd0, gain_q, 1'b1);
                last_d = 1'b1;
              end else begin
                idx_d = nidx;
                rep_d = nrep;
                iq_d  = stf_sample(nidx, gain_q, 1'b0);
              end
`else
              idx_d  = nidx;
              rep_d  = nrep;
              iq_d   = stf_sample(nidx, gain_q, 1'b0);
              last_d = (nidx == 4'd15) && (nrep == LAST_REP);
`endif
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_iq    = iq_q;
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_l_stf_stream_gen.sv
// Scoreboard bench for l_stf_stream_gen: default build (16-bit, 10 reps) plus a 12-bit, 2-rep instance.
module tb_l_stf_stream_gen;

  localparam int NR_A = 10;
  localparam int NR_B = 2;
`ifdef STF_WINDOW_EN
  localparam int WIN = 1;
  localparam logic [31:0] FIRST_G0 = 32'h0179_0179;
  localparam logic [31:0] FIRST_G1 = 32'h00bc_00bc;
  localparam logic [31:0] FIRST_B  = 32'h0001_7017;
`else
  localparam int WIN = 0;
  localparam logic [31:0] FIRST_G0 = 32'h02f2_02f2;
  localparam logic [31:0] FIRST_G1 = 32'h0179_0179;
  localparam logic [31:0] FIRST_B  = 32'h0002_f02f;
`endif
  localparam int LEN_A = 16 * NR_A + WIN;
  localparam int LEN_B = 16 * NR_B + WIN;

  typedef struct packed {
    logic [31:0] iq;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0;
  logic [1:0] gain_a = 2'd0, gain_b = 2'd0;
  logic busy_a, done_sig_a, busy_b, done_sig_b;

  l_stf_stream_gen_if #(.IQ_WIDTH(16)) bus_a ();
  l_stf_stream_gen_if #(.IQ_WIDTH(12)) bus_b ();

  l_stf_stream_gen #(.IQ_WIDTH(16), .NUM_REP(NR_A)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a), .gain_sel(gain_a),
    .bus(bus_a), .busy(busy_a), .done(done_sig_a));

  l_stf_stream_gen #(.IQ_WIDTH(12), .NUM_REP(NR_B)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b), .gain_sel(gain_b),
    .bus(bus_b), .busy(busy_b), .done(done_sig_b));

  always #5 clk = ~clk;

  logic [15:0] tab_i [8] = '{16'h02f2, 16'h0000, 16'hfd0e, 16'h042a,
                             16'hfd0e, 16'h0000, 16'h02f2, 16'hfbd6};
  logic [15:0] tab_q [8] = '{16'h02f2, 16'hfbd6, 16'h02f2, 16'h0000,
                             16'hfd0e, 16'h042a, 16'hfd0e, 16'h0000};

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad = 0;
  int cnt_a = 0, cnt_b = 0, done_a = 0, done_b = 0;
  logic [31:0] cap_a [256];
  logic [31:0] cap_b [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=completion at %0t", name, $time);
  endtask

  // Reference: transfer k of a burst, table value floor-shifted by width drop, gain and window.
  function automatic logic signed [15:0] mval(input int k, input int g, input int reps,
                                              input int drop, input bit is_q);
    int idx;
    int sh;
    logic signed [15:0] v;
    idx = k % 16;
    sh  = drop + g;
    if (WIN == 1 && (k == 0 || k == 16 * reps)) begin
      sh  = sh + 1;
      idx = 0;
    end
    v = is_q ? tab_q[idx % 8] : tab_i[idx % 8];
    return v >>> sh;
  endfunction

  task automatic push_a(input int g, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.iq   = {mval(k, g, NR_A, 0, 1'b0), mval(k, g, NR_A, 0, 1'b1)};
      e.last = (k == LEN_A - 1);
      qa.push_back(e);
    end
  endtask

  task automatic push_b(input int g);
    exp_t e;
    logic signed [15:0] vi, vq;
    for (int k = 0; k < LEN_B; k++) begin
      vi     = mval(k, g, NR_B, 4, 1'b0);
      vq     = mval(k, g, NR_B, 4, 1'b1);
      e.iq   = {8'h00, vi[11:0], vq[11:0]};
      e.last = (k == LEN_B - 1);
      qb.push_back(e);
    end
  endtask

  // Monitor A: scoreboard pop on transfer, stall-hold check, done pulse count.
  initial begin
    logic stall_prev;
    logic [31:0] prev_iq;
    logic prev_last;
    exp_t e;
    stall_prev = 1'b0;
    prev_iq = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("a_hold_iq", bus_a.o_iq, prev_iq);
          check("a_hold_last", 32'(bus_a.o_last), 32'(prev_last));
          check("a_hold_valid", 32'(bus_a.o_valid), 32'd1);
        end
        if (bus_a.o_valid && bus_a.i_ready) begin
          if (qa.size() == 0) begin
            timeout("a_unexpected_transfer");
          end else begin
            e = qa.pop_front();
            check("a_iq", bus_a.o_iq, e.iq);
            check("a_last", 32'(bus_a.o_last), 32'(e.last));
          end
          if (cnt_a < 256) cap_a[cnt_a] = bus_a.o_iq;
          cnt_a++;
        end
        if (done_sig_a) done_a++;
        stall_prev = bus_a.o_valid && !bus_a.i_ready && !abort_a;
        prev_iq    = bus_a.o_iq;
        prev_last  = bus_a.o_last;
      end
    end
  end

  // Monitor B: scoreboard for the 12-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus_b.o_valid && bus_b.i_ready) begin
          if (qb.size() == 0) begin
            timeout("b_unexpected_transfer");
          end else begin
            e = qb.pop_front();
            check("b_iq", 32'(bus_b.o_iq), e.iq);
            check("b_last", 32'(bus_b.o_last), 32'(e.last));
          end
          if (cnt_b < 64) cap_b[cnt_b] = 32'(bus_b.o_iq);
          cnt_b++;
        end
        if (done_sig_b) done_b++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst_a(input int g);
    cnt_a = 0;
    done_a = 0;
    check("a_pre_valid", 32'(bus_a.o_valid), 32'd0);
    gain_a  = 2'(g);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("a_lat_valid", 32'(bus_a.o_valid), 32'd1);
    check("a_lat_busy", 32'(busy_a), 32'd1);
  endtask

  task automatic wait_end_a(input int bound);
    int i;
    for (i = 0; i < bound && busy_a; i++) step();
    if (busy_a) timeout("a_burst_end");
    step();
    step();
  endtask

  task automatic end_checks_a();
    check("a_count", 32'(cnt_a), 32'(LEN_A));
    check("a_done_pulses", 32'(done_a), 32'd1);
    check("a_queue_left", 32'(qa.size()), 32'd0);
    check("a_busy_end", 32'(busy_a), 32'd0);
  endtask

  initial begin
    int i;
    bus_a.i_ready = 1'b1;
    bus_b.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_iq", bus_a.o_iq, 32'd0);
    check("rst_valid", 32'(bus_a.o_valid), 32'd0);
    check("rst_last", 32'(bus_a.o_last), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_sig_a), 32'd0);
    rstn = 1'b1;
    step();

    // Plain burst, gain 0, always ready
    push_a(0, LEN_A);
    begin_burst_a(0);
    wait_end_a(400);
    end_checks_a();
    check("g0_s0", cap_a[0], FIRST_G0);
    check("g0_s1", cap_a[1], 32'h0000_fbd6);
    check("g0_s159", cap_a[159], 32'hfbd6_0000);
`ifdef STF_WINDOW_EN
    check("g0_tail", cap_a[160], 32'h0179_0179);
`endif

    // Gain 1
    push_a(1, LEN_A);
    begin_burst_a(1);
    wait_end_a(400);
    end_checks_a();
    check("g1_s0", cap_a[0], FIRST_G1);
    check("g1_s1", cap_a[1], 32'h0000_fdeb);

    // Gain 3, with gain_sel changed mid-burst
    push_a(3, LEN_A);
    begin_burst_a(3);
    step();
    gain_a = 2'd0;
    wait_end_a(400);
    end_checks_a();
    check("g3_s3", cap_a[3], 32'h0085_0000);

    // Random backpressure
    push_a(0, LEN_A);
    begin_burst_a(0);
    for (i = 0; i < 2000; i++) begin
      step();
      bus_a.i_ready = 1'($urandom_range(0, 1));
      if (!busy_a) break;
    end
    if (busy_a) timeout("a_stall_burst");
    bus_a.i_ready = 1'b1;
    step();
    step();
    end_checks_a();

    // Abort after 37 transfers
    push_a(0, 37);
    begin_burst_a(0);
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      if (cnt_a >= 37) break;
    end
    #1;
    if (cnt_a < 37) timeout("a_abort_wait");
    bus_a.i_ready = 1'b0;
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("ab_valid", 32'(bus_a.o_valid), 32'd0);
    check("ab_busy", 32'(busy_a), 32'd0);
    check("ab_last", 32'(bus_a.o_last), 32'd0);
    bus_a.i_ready = 1'b1;
    repeat (4) step();
    check("ab_count", 32'(cnt_a), 32'd37);
    check("ab_no_done", 32'(done_a), 32'd0);
    check("ab_queue_left", 32'(qa.size()), 32'd0);
    push_a(0, LEN_A);
    begin_burst_a(0);
    wait_end_a(400);
    end_checks_a();
    check("ab_restart_s0", cap_a[0], FIRST_G0);

    // start reasserted mid-burst is ignored
    push_a(0, LEN_A);
    begin_burst_a(0);
    repeat (20) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_end_a(400);
    end_checks_a();

    // Asynchronous reset mid-burst
    push_a(0, LEN_A);
    begin_burst_a(0);
    repeat (20) step();
    #1;
    rstn = 1'b0;
    #1;
    check("ar_valid", 32'(bus_a.o_valid), 32'd0);
    check("ar_iq", bus_a.o_iq, 32'd0);
    check("ar_last", 32'(bus_a.o_last), 32'd0);
    check("ar_busy", 32'(busy_a), 32'd0);
    qa.delete();
    step();
    rstn = 1'b1;
    step();
    check("ar_valid_after", 32'(bus_a.o_valid), 32'd0);

    // 12-bit, 2-rep instance
    push_b(0);
    cnt_b = 0;
    done_b = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_lat_valid", 32'(bus_b.o_valid), 32'd1);
    for (i = 0; i < 200 && busy_b; i++) step();
    if (busy_b) timeout("b_burst_end");
    step();
    step();
    check("b_count", 32'(cnt_b), 32'(LEN_B));
    check("b_done_pulses", 32'(done_b), 32'd1);
    check("b_queue_left", 32'(qb.size()), 32'd0);
    check("b_s0", cap_b[0], FIRST_B);
`ifdef STF_WINDOW_EN
    check("b_tail", cap_b[32], 32'h0001_7017);
`else
    check("b_s31", cap_b[31], 32'h00fb_d000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
